// File: rtl/spram_port_arbiter.sv
// Round-robin arbiter sharing one SP256K SPRAM between two clients, each relocated into its own half.
// Optional grant/contention counters are enabled by defining SPRAM_ARB_STATS_EN.
module spram_port_arbiter #(
    parameter int PKT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int PART_DEPTH = 8000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c0_req_i,
    input  logic                  c0_we_i,
    input  logic [ADDR_WIDTH-1:0] c0_addr_i,
    input  logic [PKT_WIDTH-1:0]  c0_wdata_i,
    output logic                  c0_gnt_o,
    output logic                  c0_rvalid_o,
    output logic [PKT_WIDTH-1:0]  c0_rdata_o,
    input  logic                  c1_req_i,
    input  logic                  c1_we_i,
    input  logic [ADDR_WIDTH-1:0] c1_addr_i,
    input  logic [PKT_WIDTH-1:0]  c1_wdata_i,
    output logic                  c1_gnt_o,
    output logic                  c1_rvalid_o,
    output logic [PKT_WIDTH-1:0]  c1_rdata_o,
    output logic                  spram_we_o,
    output logic [ADDR_WIDTH-1:0] spram_ad_o,
    output logic [PKT_WIDTH-1:0]  spram_di_o,
    input  logic [PKT_WIDTH-1:0]  spram_do_i,
`ifdef SPRAM_ARB_STATS_EN
    output logic [15:0]           gnt_cnt0_o,
    output logic [15:0]           gnt_cnt1_o,
    output logic [15:0]           contend_cnt_o,
`endif
    output logic                  error_o
);

    localparam logic [ADDR_WIDTH-1:0] PART_DEPTH_W = ADDR_WIDTH'(PART_DEPTH);

    if (PKT_WIDTH != 16) begin : g_bad_pkt
        $fatal(1, "spram_port_arbiter: PKT_WIDTH must be 16");
    end
    if (ADDR_WIDTH != 14) begin : g_bad_addr
        $fatal(1, "spram_port_arbiter: ADDR_WIDTH must be 14");
    end
    if (2 * PART_DEPTH > 16000) begin : g_bad_part
        $fatal(1, "spram_port_arbiter: 2*PART_DEPTH must be <= 16000");
    end

    logic                  prio_r;
    logic                  gnt0_s, gnt1_s;
    logic                  sel_we_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [PKT_WIDTH-1:0]  sel_wdata_s;
    logic                  oor_s;
    logic                  rd_v1_r, rd_id1_r, rd_oor1_r;
    logic                  rvalid0_r, rvalid1_r;
    logic [PKT_WIDTH-1:0]  rdata0_r, rdata1_r;
    logic                  error_r;

    // Grant selection and mux of the winning client onto the SPRAM port
    always_comb begin
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (c0_req_i && (!c1_req_i || !prio_r)) begin
            gnt0_s = 1'b1;
        end else if (c1_req_i) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
        end
        if (gnt0_s) begin
            sel_we_s    = c0_we_i;
            sel_addr_s  = c0_addr_i;
            sel_wdata_s = c0_wdata_i;
        end else if (gnt1_s) begin
            sel_we_s    = c1_we_i;
            sel_addr_s  = c1_addr_i;
            sel_wdata_s = c1_wdata_i;
        end else begin
            sel_we_s    = 1'b0;
        end
    end

    // Out-of-range accesses are still granted so a bad client cannot deadlock the port
    assign oor_s      = (gnt0_s || gnt1_s) && (sel_addr_s >= PART_DEPTH_W);
    assign spram_we_o = sel_we_s && !oor_s;
    assign spram_ad_o = gnt1_s ? (sel_addr_s + PART_DEPTH_W) : sel_addr_s;
    assign spram_di_o = sel_wdata_s;
    assign c0_gnt_o   = gnt0_s;
    assign c1_gnt_o   = gnt1_s;

    // Priority toggle, two-stage read tag pipeline, returned data and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r    <= 1'b0;
            rd_v1_r   <= 1'b0;
            rd_id1_r  <= 1'b0;
            rd_oor1_r <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= '0;
            rdata1_r  <= '0;
            error_r   <= 1'b0;
        end else begin
            if (gnt0_s) begin
                prio_r <= 1'b1;
            end else if (gnt1_s) begin
                prio_r <= 1'b0;
            end else begin
                prio_r <= prio_r;
            end
            rd_v1_r   <= (gnt0_s || gnt1_s) && !sel_we_s;
            rd_id1_r  <= gnt1_s;
            rd_oor1_r <= oor_s;
            rvalid0_r <= rd_v1_r && !rd_id1_r;
            rvalid1_r <= rd_v1_r && rd_id1_r;
            if (rd_v1_r && !rd_id1_r) begin
                rdata0_r <= rd_oor1_r ? '0 : spram_do_i;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (rd_v1_r && rd_id1_r) begin
                rdata1_r <= rd_oor1_r ? '0 : spram_do_i;
            end else begin
                rdata1_r <= rdata1_r;
            end
            error_r <= error_r || oor_s;
        end
    end

    assign c0_rvalid_o = rvalid0_r;
    assign c1_rvalid_o = rvalid1_r;
    assign c0_rdata_o  = rdata0_r;
    assign c1_rdata_o  = rdata1_r;
    assign error_o     = error_r;

`ifdef SPRAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0_r, gnt_cnt1_r, contend_cnt_r;

    // Saturating grant and contention counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_r    <= 16'd0;
            gnt_cnt1_r    <= 16'd0;
            contend_cnt_r <= 16'd0;
        end else begin
            if (gnt0_s && (gnt_cnt0_r != 16'hFFFF)) begin
                gnt_cnt0_r <= gnt_cnt0_r + 16'd1;
            end else begin
                gnt_cnt0_r <= gnt_cnt0_r;
            end
            if (gnt1_s && (gnt_cnt1_r != 16'hFFFF)) begin
                gnt_cnt1_r <= gnt_cnt1_r + 16'd1;
            end else begin
                gnt_cnt1_r <= gnt_cnt1_r;
            end
            if (c0_req_i && c1_req_i && (contend_cnt_r != 16'hFFFF)) begin
                contend_cnt_r <= contend_cnt_r + 16'd1;
            end else begin
                contend_cnt_r <= contend_cnt_r;
            end
        end
    end

    assign gnt_cnt0_o    = gnt_cnt0_r;
    assign gnt_cnt1_o    = gnt_cnt1_r;
    assign contend_cnt_o = contend_cnt_r;
`endif

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Directed, table-driven bench for spram_port_arbiter with a behavioural SP256K model.
module tb_spram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [13:0] c0_addr, c1_addr;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
    logic [15:0] c0_rdata, c1_rdata;
    logic        spram_we;
    logic [13:0] spram_ad;
    logic [15:0] spram_di, spram_do;
    logic        error;
`ifdef SPRAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, contend_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req_i(c0_req), .c0_we_i(c0_we), .c0_addr_i(c0_addr), .c0_wdata_i(c0_wdata),
        .c0_gnt_o(c0_gnt), .c0_rvalid_o(c0_rvalid), .c0_rdata_o(c0_rdata),
        .c1_req_i(c1_req), .c1_we_i(c1_we), .c1_addr_i(c1_addr), .c1_wdata_i(c1_wdata),
        .c1_gnt_o(c1_gnt), .c1_rvalid_o(c1_rvalid), .c1_rdata_o(c1_rdata),
        .spram_we_o(spram_we), .spram_ad_o(spram_ad), .spram_di_o(spram_di),
        .spram_do_i(spram_do),
`ifdef SPRAM_ARB_STATS_EN
        .gnt_cnt0_o(gnt_cnt0), .gnt_cnt1_o(gnt_cnt1), .contend_cnt_o(contend_cnt),
`endif
        .error_o(error)
    );

    // SP256K behaviour: address captured at the edge, DO valid the following cycle
    logic [15:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    always @(posedge clk) begin
        if (spram_we) mem[spram_ad] <= spram_di;
        spram_do <= mem[spram_ad];
    end

    typedef struct {
        logic        r0, w0;
        logic [13:0] a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [13:0] a1;
        logic [15:0] d1;
        logic        g0, g1, we;
        logic [13:0] ad;
        logic [15:0] di;
        logic        rv0, rv1;
        logic [15:0] rd0, rd1;
        logic        err;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic r0, w0, input logic [13:0] a0, input logic [15:0] d0,
        input logic r1, w1, input logic [13:0] a1, input logic [15:0] d1,
        input logic g0, g1, we, input logic [13:0] ad, input logic [15:0] di,
        input logic rv0, rv1, input logic [15:0] rd0, rd1, input logic err);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.ad = ad; v.di = di;
        v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0, w0, input logic [13:0] a0, input logic [15:0] d0,
                         input logic r1, w1, input logic [13:0] a1, input logic [15:0] d1);
        c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
    endtask

    initial begin
        // inputs (c0 req,we,addr,data, c1 req,we,addr,data) | g0 g1 we ad di rv0 rv1 rd0 rd1 err
        tbl[0]  = mk(1'b1,1'b1,14'd5,16'hA5A5, 1'b0,1'b0,14'd0,16'h0, 1'b1,1'b0,1'b1,14'd5,16'hA5A5,     1'b0,1'b0,16'h0,16'h0,1'b0);
        tbl[1]  = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b0,16'h0,16'h0,1'b0);
        tbl[2]  = mk(1'b1,1'b0,14'd5,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b1,1'b0,1'b0,14'd5,16'h0,        1'b0,1'b0,16'h0,16'h0,1'b0);
        tbl[3]  = mk(1'b0,1'b0,14'd0,16'h0,    1'b1,1'b1,14'd5,16'h1234, 1'b0,1'b1,1'b1,14'd8005,16'h1234, 1'b0,1'b0,16'h0,16'h0,1'b0);
        tbl[4]  = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b1,1'b0,16'hA5A5,16'h0,1'b0);
        tbl[5]  = mk(1'b1,1'b0,14'd5,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b1,1'b0,1'b0,14'd5,16'h0,        1'b0,1'b0,16'hA5A5,16'h0,1'b0);
        tbl[6]  = mk(1'b0,1'b0,14'd0,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b0,1'b1,1'b0,14'd8005,16'h0,     1'b0,1'b0,16'hA5A5,16'h0,1'b0);
        tbl[7]  = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b1,1'b0,16'hA5A5,16'h0,1'b0);
        tbl[8]  = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b1,16'hA5A5,16'h1234,1'b0);
        tbl[9]  = mk(1'b1,1'b0,14'd5,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b1,1'b0,1'b0,14'd5,16'h0,        1'b0,1'b0,16'hA5A5,16'h1234,1'b0);
        tbl[10] = mk(1'b1,1'b0,14'd5,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b0,1'b1,1'b0,14'd8005,16'h0,     1'b0,1'b0,16'hA5A5,16'h1234,1'b0);
        tbl[11] = mk(1'b1,1'b0,14'd5,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b1,1'b0,1'b0,14'd5,16'h0,        1'b1,1'b0,16'hA5A5,16'h1234,1'b0);
        tbl[12] = mk(1'b1,1'b0,14'd5,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b0,1'b1,1'b0,14'd8005,16'h0,     1'b0,1'b1,16'hA5A5,16'h1234,1'b0);
        tbl[13] = mk(1'b1,1'b0,14'd5,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b1,1'b0,1'b0,14'd5,16'h0,        1'b1,1'b0,16'hA5A5,16'h1234,1'b0);
        tbl[14] = mk(1'b1,1'b0,14'd5,16'h0,    1'b1,1'b0,14'd5,16'h0, 1'b0,1'b1,1'b0,14'd8005,16'h0,     1'b0,1'b1,16'hA5A5,16'h1234,1'b0);
        tbl[15] = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b1,1'b0,16'hA5A5,16'h1234,1'b0);
        tbl[16] = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b1,16'hA5A5,16'h1234,1'b0);
        tbl[17] = mk(1'b0,1'b0,14'd0,16'h0,    1'b1,1'b0,14'd8000,16'h0, 1'b0,1'b1,1'b0,14'd16000,16'h0, 1'b0,1'b0,16'hA5A5,16'h1234,1'b0);
        tbl[18] = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b0,16'hA5A5,16'h1234,1'b1);
        tbl[19] = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b1,16'hA5A5,16'h0,1'b1);
        tbl[20] = mk(1'b1,1'b1,14'd8000,16'hFFFF, 1'b0,1'b0,14'd0,16'h0, 1'b1,1'b0,1'b0,14'd8000,16'hFFFF, 1'b0,1'b0,16'hA5A5,16'h0,1'b1);
        tbl[21] = mk(1'b0,1'b0,14'd0,16'h0,    1'b1,1'b0,14'd0,16'h0, 1'b0,1'b1,1'b0,14'd8000,16'h0,     1'b0,1'b0,16'hA5A5,16'h0,1'b1);
        tbl[22] = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b0,16'hA5A5,16'h0,1'b1);
        tbl[23] = mk(1'b0,1'b0,14'd0,16'h0,    1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,1'b0,14'd0,16'h0,        1'b0,1'b1,16'hA5A5,16'h0,1'b1);

        rst_n = 1'b0;
        drive(1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,14'd0,16'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset c0_rvalid", 16'(c0_rvalid), 16'h0);
        chk("reset c1_rvalid", 16'(c1_rvalid), 16'h0);
        chk("reset c0_rdata", c0_rdata, 16'h0);
        chk("reset c1_rdata", c1_rdata, 16'h0);
        chk("reset error", 16'(error), 16'h0);
        chk("reset spram_ad", 16'(spram_ad), 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            #4;
            chk($sformatf("v%0d c0_gnt", i), 16'(c0_gnt), 16'(tbl[i].g0));
            chk($sformatf("v%0d c1_gnt", i), 16'(c1_gnt), 16'(tbl[i].g1));
            chk($sformatf("v%0d spram_we", i), 16'(spram_we), 16'(tbl[i].we));
            chk($sformatf("v%0d spram_ad", i), 16'(spram_ad), 16'(tbl[i].ad));
            chk($sformatf("v%0d spram_di", i), spram_di, tbl[i].di);
            chk($sformatf("v%0d c0_rvalid", i), 16'(c0_rvalid), 16'(tbl[i].rv0));
            chk($sformatf("v%0d c1_rvalid", i), 16'(c1_rvalid), 16'(tbl[i].rv1));
            chk($sformatf("v%0d c0_rdata", i), c0_rdata, tbl[i].rd0);
            chk($sformatf("v%0d c1_rdata", i), c1_rdata, tbl[i].rd1);
            chk($sformatf("v%0d error", i), 16'(error), 16'(tbl[i].err));
        end

        // Reset landing one cycle after a c0 read grant: the read must vanish and prio return to c0
        @(posedge clk);
        #1;
        drive(1'b1,1'b0,14'd5,16'h0, 1'b0,1'b0,14'd0,16'h0);
        #4;
        chk("rstseq c0_gnt", 16'(c0_gnt), 16'h1);
        @(posedge clk);
        #1;
        drive(1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,14'd0,16'h0);
        rst_n = 1'b0;
        #4;
        chk("rstseq c0_rdata", c0_rdata, 16'h0);
        chk("rstseq error", 16'(error), 16'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #5;
            chk($sformatf("rstseq c0_rvalid %0d", k), 16'(c0_rvalid), 16'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1,1'b0,14'd5,16'h0, 1'b1,1'b0,14'd5,16'h0);
        #4;
        chk("rstseq contested c0_gnt", 16'(c0_gnt), 16'h1);
        chk("rstseq contested c1_gnt", 16'(c1_gnt), 16'h0);
        chk("rstseq c0_rvalid after", 16'(c0_rvalid), 16'h0);
        chk("rstseq c0_rdata after", c0_rdata, 16'h0);
        @(posedge clk);
        #1;
        drive(1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,14'd0,16'h0);

`ifdef SPRAM_ARB_STATS_EN
        // Fresh reset, 3 contested cycles then 2 solo c0 grants
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1,1'b0,14'd1,16'h0, 1'b1,1'b0,14'd1,16'h0);
        repeat (3) @(posedge clk);
        #1;
        drive(1'b1,1'b0,14'd1,16'h0, 1'b0,1'b0,14'd0,16'h0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b0,1'b0,14'd0,16'h0, 1'b0,1'b0,14'd0,16'h0);
        #4;
        chk("stats gnt_cnt0", gnt_cnt0, 16'd4);
        chk("stats gnt_cnt1", gnt_cnt1, 16'd1);
        chk("stats contend_cnt", contend_cnt, 16'd3);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
